sbn_dmem_arbiter: RTL
=====================

Name: sbn_dmem_arbiter

Overview:
- Shares the single-port SBN data memory between two requesters: port C (SBN core datapath) and port H (host loader/debug).
- Two-way round-robin arbitration with a lock mechanism, so the core's read-A / read-B / write-C sequence for one sbn instruction is atomic against host traffic.
- Lock timeout guards against a hung owner.
- Sits between the sbn core, the host port and the dmem array. The memory has a 1-cycle synchronous read.

Parameters:
- FWIDTH, 8, address width; memory depth 2**FWIDTH.
- DWIDTH, 32, data width.
- LOCK_MAX, 16, maximum cycles a lock may be held before forced release (≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (1=write, 0=read)
- c_lock  in  1  core keeps ownership after this access
- c_addr  in  FWIDTH  core address
- c_wdata  in  DWIDTH  core write data
- c_gnt  out  1  core access accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DWIDTH  core read data
- h_req, h_we, h_lock, h_addr, h_wdata  in  1/1/1/FWIDTH/DWIDTH  host equivalents
- h_gnt, h_rvalid, h_rdata  out  1/1/DWIDTH  host equivalents
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  FWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_en & !mem_we
- lock_err  out  1  sticky: a lock was force-released

Behaviour:
- Clock/reset: one clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, last=H (core wins the first tie), lock counter=0, c_rvalid=h_rvalid=0, lock_err=0.
- Request rule: a requester holds req and all its fields stable until it sees gnt high. At most one access is performed per cycle.
- gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from the current state and the requests. mem_* carry the granted port's fields. mem_en = c_gnt | h_gnt.
- Read latency: a granted read produces the requester's rvalid=1 exactly one cycle later, for one cycle. c_rdata = h_rdata = mem_rdata. Writes produce no rvalid.
- FSM states: IDLE, LOCK_C, LOCK_H.
- IDLE:
  - Exactly one req → grant it.
  - Both req → grant the port not equal to last.
  - last updates to the granted port.
  - If the granted access has lock=1 → next state is LOCK_<port>, and the counter loads 0.
- LOCK_X:
  - Only X may be granted; the other port waits, with its gnt held at 0.
  - A granted access from X with lock=0 → next state IDLE; the release access itself completes.
  - A granted access from X with lock=1 → stay in LOCK_X, counter reloads 0.
  - Each cycle without an X grant increments the counter.
  - When the counter reaches LOCK_MAX-1 with no X grant → next state IDLE and lock_err=1. No grant is issued in that cycle.
- Counter arithmetic: width clog2(LOCK_MAX)+1; it never wraps.
- Simultaneous events: in LOCK_X, an X grant takes precedence over timeout in the same cycle. A release and a waiting request from the other port in the same cycle → the other port is granted the next cycle.
- lock_err clears only on reset.
- Reset mid-lock: ownership is dropped, and rvalids fall at the reset edge. An outstanding read's data is discarded.
- No grants while rst_n=0.

Optional Feature:
- SBN_ARB_STATS_EN: adds outputs c_gnt_cnt and h_gnt_cnt (each 16 bits) and stall_cnt (16 bits, increments each cycle a req is pending without gnt on either port).
  - All three are saturating and zero on reset.
- Without the macro these ports and counters do not exist.
- Arbitration behaviour is identical either way.

Decomposition:
- Package sbn_arb_pkg: state encoding constants (IDLE=2'd0, LOCK_C=2'd1, LOCK_H=2'd2), port index constants (PORT_C=0, PORT_H=1), default widths.
- One natural sub-module: sbn_arb_lock_timer, which holds the lock counter with load/inc/expire.
- Stats counters stay inline under the macro.

Test Plan:
- Reset then c_req read addr 0x05, mem holds 0x0000002A:
  - c_gnt=1 in the same cycle, mem_addr=0x05.
  - Next cycle c_rvalid=1, c_rdata=0x2A; h_rvalid stays 0.
- Both ports request reads continuously:
  - Grants alternate C, H, C, H starting with C after reset.
  - Each port gets exactly 4 grants in 8 cycles.
- Core sequence read 0x10 (lock=1), read 0x11 (lock=1), write 0x12=0xFFFFFFFF (lock=0) while h_req is held high:
  - h_gnt=0 throughout.
  - h_gnt=1 on the cycle after the write grant.
- Host sets h_lock=1 on one write, then drops h_req with LOCK_MAX=16:
  - 16 cycles later the state returns to IDLE and lock_err=1.
  - A pending c_req is then granted; lock_err stays 1 until rst_n=0.
- rst_n=0 asserted the cycle after a granted core read:
  - c_rvalid=0 at that edge and state=IDLE.
  - After release, the first tie goes to C.
- With SBN_ARB_STATS_EN, 3 core and 2 host grants:
  - c_gnt_cnt=3, h_gnt_cnt=2.
  - stall_cnt equals the counted waiting cycles.

Source files
------------

// File: rtl/sbn_arb_pkg.sv
// -----------------------------------------------------------------------------
// sbn_arb_pkg
// Shared definitions for the SBN data-memory arbiter: FSM state encoding,
// port index constants, default widths and the lock-counter width helper.
// Optional feature macro used by the arbiter: SBN_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package sbn_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_C = 2'd1,
        ST_LOCK_H = 2'd2
    } arb_state_e;

    localparam int PORT_C = 0;
    localparam int PORT_H = 1;

    localparam int DEF_FWIDTH   = 8;
    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_LOCK_MAX = 16;

    localparam int STAT_W = 16;

    // Lock counter needs to hold LOCK_MAX-1 with headroom; one extra bit
    // keeps the saturation compare trivially safe.
    function automatic int lock_cnt_w(input int lock_max);
        return $clog2(lock_max) + 1;
    endfunction

endpackage

// File: rtl/sbn_arb_lock_timer.sv
// -----------------------------------------------------------------------------
// sbn_arb_lock_timer
// Counts cycles a lock owner has gone without being granted. Loads zero on
// i_load, otherwise increments on i_inc and saturates at LOCK_MAX-1.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : clear counter to 0 (has priority over i_inc)
//   i_inc          : advance counter by one (saturating)
//   o_at_max       : counter currently equals LOCK_MAX-1
// -----------------------------------------------------------------------------
module sbn_arb_lock_timer
    import sbn_arb_pkg::*;
#(
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int CW = lock_cnt_w(LOCK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == CNT_LAST);
    assign o_at_max = w_at_max;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sbn_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// sbn_dmem_arbiter
// Shares the single-port SBN data memory between the core (port C) and the
// host loader/debug port (port H). Two-way round robin with a lock so the
// core's read-A/read-B/write-C sequence is atomic; a stalled lock owner is
// force-released after LOCK_MAX cycles and flagged on o_lock_err (sticky).
// Optional: define SBN_ARB_STATS_EN to add grant/stall statistic counters.
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_c_* / o_c_*             : core request (req/we/lock/addr/wdata),
//                               grant, read valid, read data
//   i_h_* / o_h_*             : host equivalents
//   o_mem_en/we/addr/wdata    : memory command (granted port's fields)
//   i_mem_rdata               : memory read data, one cycle after a read
//   o_lock_err                : sticky, a lock was force-released
//   o_c_gnt_cnt, o_h_gnt_cnt,
//   o_stall_cnt               : saturating stats (SBN_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module sbn_dmem_arbiter
    import sbn_arb_pkg::*;
#(
    parameter int FWIDTH   = DEF_FWIDTH,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic              i_c_lock,
    input  logic [FWIDTH-1:0] i_c_addr,
    input  logic [DWIDTH-1:0] i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DWIDTH-1:0] o_c_rdata,
    input  logic              i_h_req,
    input  logic              i_h_we,
    input  logic              i_h_lock,
    input  logic [FWIDTH-1:0] i_h_addr,
    input  logic [DWIDTH-1:0] i_h_wdata,
    output logic              o_h_gnt,
    output logic              o_h_rvalid,
    output logic [DWIDTH-1:0] o_h_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [FWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_lock_err
`ifdef SBN_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] o_c_gnt_cnt,
    output logic [STAT_W-1:0] o_h_gnt_cnt,
    output logic [STAT_W-1:0] o_stall_cnt
`endif
);

    localparam logic LAST_C = 1'(PORT_C);
    localparam logic LAST_H = 1'(PORT_H);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last;
    logic       r_c_rvalid;
    logic       r_h_rvalid;
    logic       r_lock_err;

    logic       w_c_gnt;
    logic       w_h_gnt;
    logic       w_expire;
    logic       w_at_max;
    logic       w_tmr_load;

    // -------------------------------------------------------------------------
    // Arbitration / next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_c_gnt     = 1'b0;
        w_h_gnt     = 1'b0;
        w_expire    = 1'b0;
        w_state_nxt = r_state;
        if (i_rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie the port that did not win last time goes.
                    w_c_gnt = i_c_req & (~i_h_req | (r_last == LAST_H));
                    w_h_gnt = i_h_req & ~w_c_gnt;
                    if (w_c_gnt && i_c_lock)
                        w_state_nxt = ST_LOCK_C;
                    else if (w_h_gnt && i_h_lock)
                        w_state_nxt = ST_LOCK_H;
                end
                ST_LOCK_C: begin
                    // Owner grant beats the timeout in the same cycle.
                    w_c_gnt = i_c_req;
                    if (w_c_gnt) begin
                        w_state_nxt = i_c_lock ? ST_LOCK_C : ST_IDLE;
                    end else if (w_at_max) begin
                        w_expire    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCK_H: begin
                    w_h_gnt = i_h_req;
                    if (w_h_gnt) begin
                        w_state_nxt = i_h_lock ? ST_LOCK_H : ST_IDLE;
                    end else if (w_at_max) begin
                        w_expire    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= LAST_H;
            r_c_rvalid <= 1'b0;
            r_h_rvalid <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (w_c_gnt)
                r_last <= LAST_C;
            else if (w_h_gnt)
                r_last <= LAST_H;
            r_c_rvalid <= w_c_gnt & ~i_c_we;
            r_h_rvalid <= w_h_gnt & ~i_h_we;
            if (w_expire)
                r_lock_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Lock timer: held at zero outside a lock and on every owner grant, so
    // it only counts consecutive owner-idle cycles inside a lock.
    // -------------------------------------------------------------------------
    assign w_tmr_load = (r_state == ST_IDLE) | w_c_gnt | w_h_gnt | w_expire;

    sbn_arb_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_tmr_load),
        .i_inc    (~w_tmr_load),
        .o_at_max (w_at_max)
    );

    // -------------------------------------------------------------------------
    // Memory command mux and response fan-out
    // -------------------------------------------------------------------------
    assign o_c_gnt     = w_c_gnt;
    assign o_h_gnt     = w_h_gnt;
    assign o_mem_en    = w_c_gnt | w_h_gnt;
    assign o_mem_we    = (w_c_gnt & i_c_we) | (w_h_gnt & i_h_we);
    assign o_mem_addr  = w_h_gnt ? i_h_addr  : i_c_addr;
    assign o_mem_wdata = w_h_gnt ? i_h_wdata : i_c_wdata;

    assign o_c_rvalid  = r_c_rvalid;
    assign o_h_rvalid  = r_h_rvalid;
    assign o_c_rdata   = i_mem_rdata;
    assign o_h_rdata   = i_mem_rdata;
    assign o_lock_err  = r_lock_err;

`ifdef SBN_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating statistics
    // -------------------------------------------------------------------------
    localparam logic [STAT_W-1:0] STAT_SAT = '1;

    logic [STAT_W-1:0] r_c_gnt_cnt;
    logic [STAT_W-1:0] r_h_gnt_cnt;
    logic [STAT_W-1:0] r_stall_cnt;
    logic              w_stall;

    assign w_stall = (i_c_req & ~w_c_gnt) | (i_h_req & ~w_h_gnt);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_c_gnt_cnt <= '0;
            r_h_gnt_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_c_gnt && r_c_gnt_cnt != STAT_SAT)
                r_c_gnt_cnt <= r_c_gnt_cnt + 1'b1;
            if (w_h_gnt && r_h_gnt_cnt != STAT_SAT)
                r_h_gnt_cnt <= r_h_gnt_cnt + 1'b1;
            if (w_stall && r_stall_cnt != STAT_SAT)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_c_gnt_cnt = r_c_gnt_cnt;
    assign o_h_gnt_cnt = r_h_gnt_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
